// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller for the on-chip SAR ADC: sample, MSB-first binary search, valid/ready result.
// Optional macro SAR_COMP_SYNC_EN adds a 2-flop comparator synchronizer and stretches each settle by 2 cycles.
module sar_adc_ctrl #(
    parameter int N_BITS        = 8,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              comp_in,
    output logic              sample_en,
    output logic [N_BITS-1:0] dac_code,
    output logic              busy,
    output logic [N_BITS-1:0] result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              overrun
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SAMPLE = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_DECIDE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

`ifdef SAR_COMP_SYNC_EN
    localparam int SETTLE_TOTAL = SETTLE_CYCLES + 2;
`else
    localparam int SETTLE_TOTAL = SETTLE_CYCLES;
`endif

    localparam int CNT_W = 16;
    localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [IDX_W-1:0]  IDX_MSB    = IDX_W'(N_BITS - 1);
    localparam logic [N_BITS-1:0] TRIAL_INIT = N_BITS'(1) << (N_BITS - 1);

    logic [2:0]        state_r,        state_s;
    logic [CNT_W-1:0]  cnt_r,          cnt_s;
    logic [IDX_W-1:0]  idx_r,          idx_s;
    logic [N_BITS-1:0] trial_r,        trial_s;
    logic [N_BITS-1:0] trial_dec_s;
    logic              sample_en_r,    sample_en_s;
    logic [N_BITS-1:0] dac_code_r,     dac_code_s;
    logic              busy_r,         busy_s;
    logic [N_BITS-1:0] result_r,       result_s;
    logic              result_valid_r, result_valid_s;
    logic              comp_s;

`ifdef SAR_COMP_SYNC_EN
    logic comp_meta_r;
    logic comp_sync_r;

    // Two-stage synchronizer for the asynchronous comparator decision
    always_ff @(posedge clk) begin
        if (rst) begin
            comp_meta_r <= 1'b0;
            comp_sync_r <= 1'b0;
        end else begin
            comp_meta_r <= comp_in;
            comp_sync_r <= comp_meta_r;
        end
    end

    assign comp_s = comp_sync_r;
`else
    assign comp_s = comp_in;
`endif

    // Next-state, datapath and handshake computation
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        idx_s          = idx_r;
        trial_s        = trial_r;
        trial_dec_s    = trial_r;
        sample_en_s    = 1'b0;
        dac_code_s     = dac_code_r;
        result_s       = result_r;

        // A transfer drains the result; DONE below may immediately reload it
        if (result_valid_r && result_ready) begin
            result_valid_s = 1'b0;
        end else begin
            result_valid_s = result_valid_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s     = ST_SAMPLE;
                    cnt_s       = '0;
                    sample_en_s = 1'b1;
                    dac_code_s  = '0;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_SAMPLE: begin
                if (cnt_r == CNT_W'(SAMPLE_CYCLES - 1)) begin
                    state_s     = ST_SETTLE;
                    cnt_s       = '0;
                    trial_s     = TRIAL_INIT;
                    dac_code_s  = TRIAL_INIT;
                    idx_s       = IDX_MSB;
                end else begin
                    cnt_s       = cnt_r + CNT_W'(1);
                    sample_en_s = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == CNT_W'(SETTLE_TOTAL - 1)) begin
                    state_s = ST_DECIDE;
                    cnt_s   = '0;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_DECIDE: begin
                if (!comp_s) begin
                    trial_dec_s[idx_r] = 1'b0;
                end else begin
                    trial_dec_s = trial_r;
                end
                if (idx_r != IDX_W'(0)) begin
                    trial_dec_s[idx_r - IDX_W'(1)] = 1'b1;
                    idx_s      = idx_r - IDX_W'(1);
                    state_s    = ST_SETTLE;
                    dac_code_s = trial_dec_s;
                end else begin
                    state_s    = ST_DONE;
                    dac_code_s = '0;
                end
                trial_s = trial_dec_s;
            end
            ST_DONE: begin
                result_s       = trial_r;
                result_valid_s = 1'b1;
                idx_s          = IDX_MSB;
                state_s        = ST_IDLE;
            end
            default: begin
                state_s    = ST_IDLE;
                cnt_s      = '0;
                idx_s      = IDX_MSB;
                dac_code_s = '0;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            cnt_r          <= '0;
            idx_r          <= IDX_MSB;
            trial_r        <= '0;
            sample_en_r    <= 1'b0;
            dac_code_r     <= '0;
            busy_r         <= 1'b0;
            result_r       <= '0;
            result_valid_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            idx_r          <= idx_s;
            trial_r        <= trial_s;
            sample_en_r    <= sample_en_s;
            dac_code_r     <= dac_code_s;
            busy_r         <= busy_s;
            result_r       <= result_s;
            result_valid_r <= result_valid_s;
        end
    end

    assign sample_en    = sample_en_r;
    assign dac_code     = dac_code_r;
    assign busy         = busy_r;
    assign result       = result_r;
    assign result_valid = result_valid_r;
    // Overrun must flag the DONE cycle itself, so it depends on this cycle's result_ready
    assign overrun      = (state_r == ST_DONE) && result_valid_r && !result_ready;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed self-checking bench for sar_adc_ctrl with a behavioural comparator (comp = dac_code <= target).
module tb_sar_adc_ctrl;

`ifdef SAR_COMP_SYNC_EN
    localparam int LAT    = 45;
    localparam int STRIDE = 5;
    localparam int B2B_NV = 2;
    localparam int B2B_NS = 12;
`else
    localparam int LAT    = 29;
    localparam int STRIDE = 3;
    localparam int B2B_NV = 3;
    localparam int B2B_NS = 16;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic       comp_in;
    logic       sample_en;
    logic [7:0] dac_code;
    logic       busy;
    logic [7:0] result;
    logic       result_valid;
    logic       result_ready;
    logic       overrun;

    logic [7:0] target;
    logic [1:0] cmode;
    int         ncmp;
    int         nerr;

    sar_adc_ctrl #(.N_BITS(8), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .comp_in      (comp_in),
        .sample_en    (sample_en),
        .dac_code     (dac_code),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overrun      (overrun)
    );

    // Analog comparator model: 0 = threshold model, 1 = stuck low, 2 = stuck high
    assign comp_in = (cmode == 2'd0) ? (dac_code <= target) :
                     (cmode == 2'd1) ? 1'b0 : 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; result_ready = 1'b0; cmode = 2'd0; target = 8'h00;
        tick(); tick();
        ncmp++;
        if ({sample_en, dac_code, busy, result, result_valid, overrun} !== 19'h0) begin
            nerr++;
            $display("FAIL reset_outputs: got %0h expected 0", {sample_en, dac_code, busy, result, result_valid, overrun});
        end
        rst = 1'b0;
        tick();
        ncmp++;
        if (busy !== 1'b0) begin nerr++; $display("FAIL reset_idle: busy=%0b expected 0", busy); end
    endtask

    task automatic test_convert_a5();
        logic [7:0] exp_seq [8];
        int         nsamp;
        exp_seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        target = 8'hA5; cmode = 2'd0; result_ready = 1'b1;
        accept_start();
        ncmp++;
        if (busy !== 1'b1 || sample_en !== 1'b1) begin
            nerr++; $display("FAIL a5_start: busy=%0b sample_en=%0b expected 1 1", busy, sample_en);
        end
        nsamp = 1;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            if (sample_en) nsamp++;
            for (int k = 0; k < 8; k++) begin
                if (i == 4 + STRIDE * k) begin
                    ncmp++;
                    if (dac_code !== exp_seq[k]) begin
                        nerr++; $display("FAIL a5_trial%0d: got %0h expected %0h", k, dac_code, exp_seq[k]);
                    end
                end
            end
            if (i == LAT - 1) begin
                ncmp++;
                if (result_valid !== 1'b0) begin nerr++; $display("FAIL a5_early_valid: got 1 expected 0 at cycle %0d", i); end
            end
        end
        ncmp++;
        if (result_valid !== 1'b1 || result !== 8'hA5) begin
            nerr++; $display("FAIL a5_result: valid=%0b result=%0h expected 1 a5", result_valid, result);
        end
        ncmp++;
        if (nsamp !== 4) begin nerr++; $display("FAIL a5_sample_cycles: got %0d expected 4", nsamp); end
        ncmp++;
        if (busy !== 1'b0) begin nerr++; $display("FAIL a5_busy_after: got %0b expected 0", busy); end
        tick();
        ncmp++;
        if (result_valid !== 1'b0) begin nerr++; $display("FAIL a5_handshake: valid=%0b expected 0", result_valid); end
    endtask

    task automatic test_extremes();
        logic [7:0] exp_res;
        for (int m = 1; m <= 2; m++) begin
            cmode = 2'(m); result_ready = 1'b1;
            exp_res = (m == 1) ? 8'h00 : 8'hFF;
            accept_start();
            for (int i = 1; i <= LAT; i++) tick();
            ncmp++;
            if (result_valid !== 1'b1 || result !== exp_res) begin
                nerr++; $display("FAIL extreme_mode%0d: valid=%0b result=%0h expected 1 %0h", m, result_valid, result, exp_res);
            end
            tick();
        end
        cmode = 2'd0;
    endtask

    task automatic test_reset_mid();
        int nv;
        target = 8'hA5; result_ready = 1'b1;
        accept_start();
        for (int i = 1; i <= 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ncmp++;
        if ({sample_en, dac_code, busy, result, result_valid, overrun} !== 19'h0) begin
            nerr++; $display("FAIL midreset_outputs: got %0h expected 0", {sample_en, dac_code, busy, result, result_valid, overrun});
        end
        nv = 0;
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            if (result_valid) nv++;
        end
        ncmp++;
        if (nv !== 0) begin nerr++; $display("FAIL midreset_no_result: valid seen %0d times expected 0", nv); end
        target = 8'h3C;
        accept_start();
        for (int i = 1; i <= LAT; i++) tick();
        ncmp++;
        if (result_valid !== 1'b1 || result !== 8'h3C) begin
            nerr++; $display("FAIL midreset_3c: valid=%0b result=%0h expected 1 3c", result_valid, result);
        end
        tick();
    endtask

    task automatic test_overrun();
        int nov;
        result_ready = 1'b0; target = 8'h11; nov = 0;
        accept_start();
        for (int i = 1; i <= LAT; i++) begin
            tick();
            if (overrun) nov++;
        end
        ncmp++;
        if (result !== 8'h11 || result_valid !== 1'b1 || nov !== 0) begin
            nerr++; $display("FAIL ovr_first: result=%0h valid=%0b ovr=%0d expected 11 1 0", result, result_valid, nov);
        end
        target = 8'h22;
        accept_start();
        for (int i = 1; i <= LAT; i++) begin
            tick();
            if (overrun) nov++;
            if (i == LAT - 1) begin
                ncmp++;
                if (overrun !== 1'b1 || result !== 8'h11) begin
                    nerr++; $display("FAIL ovr_done_cycle: overrun=%0b result=%0h expected 1 11", overrun, result);
                end
            end
        end
        ncmp++;
        if (nov !== 1 || result !== 8'h22 || result_valid !== 1'b1) begin
            nerr++; $display("FAIL ovr_second: pulses=%0d result=%0h valid=%0b expected 1 22 1", nov, result, result_valid);
        end
        tick();
        ncmp++;
        if (result_valid !== 1'b1 || result !== 8'h22) begin
            nerr++; $display("FAIL ovr_hold: valid=%0b result=%0h expected 1 22", result_valid, result);
        end
        result_ready = 1'b1;
        tick();
        ncmp++;
        if (result_valid !== 1'b0) begin nerr++; $display("FAIL ovr_drain: valid=%0b expected 0", result_valid); end
    endtask

    task automatic test_start_ignored();
        target = 8'h5A; result_ready = 1'b1;
        accept_start();
        for (int i = 1; i <= LAT; i++) begin
            start = (i == 5 || i == 15 || i == LAT - 1);
            tick();
        end
        start = 1'b0;
        ncmp++;
        if (result !== 8'h5A || result_valid !== 1'b1) begin
            nerr++; $display("FAIL ignore_result: result=%0h valid=%0b expected 5a 1", result, result_valid);
        end
        tick(); tick();
        ncmp++;
        if (busy !== 1'b0) begin nerr++; $display("FAIL ignore_not_queued: busy=%0b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int nv, ns, last, drain;
        target = 8'h77; result_ready = 1'b1;
        nv = 0; ns = 0; last = 0;
        start = 1'b1;
        tick();
        for (int c = 0; c < 100; c++) begin
            if (sample_en) ns++;
            if (result_valid) begin
                ncmp++;
                if (nv == 0 && c !== LAT) begin
                    nerr++; $display("FAIL b2b_first: valid at cycle %0d expected %0d", c, LAT);
                end else if (nv != 0 && (c - last) !== LAT + 1) begin
                    nerr++; $display("FAIL b2b_period: spacing %0d expected %0d", c - last, LAT + 1);
                end else if (result !== 8'h77) begin
                    nerr++; $display("FAIL b2b_result: got %0h expected 77", result);
                end
                nv++; last = c;
            end
            if (c == 99) start = 1'b0;
            tick();
        end
        ncmp++;
        if (nv !== B2B_NV || ns !== B2B_NS) begin
            nerr++; $display("FAIL b2b_counts: results=%0d sample_cycles=%0d expected %0d %0d", nv, ns, B2B_NV, B2B_NS);
        end
        drain = 0;
        while (busy && drain < 100) begin
            tick();
            drain++;
        end
        ncmp++;
        if (busy !== 1'b0) begin nerr++; $display("FAIL b2b_drain_timeout: busy=%0b expected 0", busy); end
        tick(); tick();
    endtask

    initial begin
        ncmp = 0; nerr = 0;
        test_reset();
        test_convert_a5();
        test_extremes();
        test_reset_mid();
        test_overrun();
        test_start_ignored();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
